// File: rtl/wb_trace_arbiter_pkg.sv
// Shared types for the write-back trace arbiter: trace entry layout {pc, wen, wnum, wdata}.
package wb_trace_arbiter_pkg;

   localparam int unsigned TRACE_ENTRY_WD = 73;

   localparam int unsigned TRACE_WDATA_LSB = 0;
   localparam int unsigned TRACE_WDATA_MSB = 31;
   localparam int unsigned TRACE_WNUM_LSB  = 32;
   localparam int unsigned TRACE_WNUM_MSB  = 36;
   localparam int unsigned TRACE_WEN_LSB   = 37;
   localparam int unsigned TRACE_WEN_MSB   = 40;
   localparam int unsigned TRACE_PC_LSB    = 41;
   localparam int unsigned TRACE_PC_MSB    = 72;

   typedef struct packed {
      logic [31:0] pc;
      logic [3:0]  wen;
      logic [4:0]  wnum;
      logic [31:0] wdata;
   } trace_entry_t;

   function automatic trace_entry_t make_entry(input logic [31:0] pc, input logic [3:0] wen,
                                               input logic [4:0] wnum, input logic [31:0] wdata);
      trace_entry_t e;
      e.pc    = pc;
      e.wen   = wen;
      e.wnum  = wnum;
      e.wdata = wdata;
      return e;
   endfunction

endpackage

// File: rtl/wb_trace_arbiter_trace_fifo.sv
// Two-write / one-read circular buffer holding trace entries in program order.
module trace_fifo
   import wb_trace_arbiter_pkg::*;
#(
   parameter int unsigned DEPTH = 4,
   localparam int unsigned AW = $clog2(DEPTH),
   localparam int unsigned CW = AW + 1
) (
   input  logic          clk,
   input  logic          resetn,
   input  logic [1:0]    push_cnt,
   input  trace_entry_t  push_entry_0,
   input  trace_entry_t  push_entry_1,
   input  logic          pop,
   output trace_entry_t  head,
   output logic [CW-1:0] count
);

   trace_entry_t  mem [DEPTH];
   logic [AW-1:0] wr_ptr_q, wr_ptr_d, wr_ptr_p1;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] count_q, count_d;

   always_comb begin
      wr_ptr_p1 = wr_ptr_q + AW'(1);
      wr_ptr_d  = wr_ptr_q + AW'(push_cnt);
      rd_ptr_d  = rd_ptr_q + AW'(pop);
      count_d   = count_q + CW'(push_cnt) - CW'(pop);
   end

   // Storage is not reset; only pointers and count define validity.
   always_ff @(posedge clk) begin
      if (push_cnt != 2'd0) mem[wr_ptr_q] <= push_entry_0;
      if (push_cnt == 2'd2) mem[wr_ptr_p1] <= push_entry_1;
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   assign head  = mem[rd_ptr_q];
   assign count = count_q;

endmodule

// File: rtl/wb_trace_arbiter.sv
// Serializes the two write-back retire lanes onto a single trace port, stalling WB when short of room.
module wb_trace_arbiter
   import wb_trace_arbiter_pkg::*;
#(
   parameter int unsigned DEPTH = 4
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic [1:0]  in_valid,
   input  logic        in_lane1_first,
   input  logic [31:0] in_pc_0,
   input  logic [31:0] in_pc_1,
   input  logic [3:0]  in_wen_0,
   input  logic [3:0]  in_wen_1,
   input  logic [4:0]  in_wnum_0,
   input  logic [4:0]  in_wnum_1,
   input  logic [31:0] in_wdata_0,
   input  logic [31:0] in_wdata_1,
   output logic        stall_req,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_pc,
   output logic [3:0]  out_wen,
   output logic [4:0]  out_wnum,
   output logic [31:0] out_wdata,
   output logic [31:0] retired_cnt
);

   localparam int unsigned CW = $clog2(DEPTH) + 1;

   trace_entry_t  lane_0, lane_1, slot_0, slot_1, head;
   logic [CW-1:0] fifo_count;
   logic          push_0, push_1, pop;
   logic [1:0]    push_cnt;
   logic [31:0]   retired_cnt_q;

   assign lane_0 = make_entry(in_pc_0, in_wen_0, in_wnum_0, in_wdata_0);
   assign lane_1 = make_entry(in_pc_1, in_wen_1, in_wnum_1, in_wdata_1);

   // Stall depends only on registered count, so there is no path from in_valid.
   assign stall_req = (fifo_count > CW'(DEPTH - 2));

   assign push_0 = in_valid[0] & (in_wen_0 != 4'd0) & ~stall_req;
   assign push_1 = in_valid[1] & (in_wen_1 != 4'd0) & ~stall_req;

   always_comb begin
      slot_0   = lane_0;
      slot_1   = lane_1;
      push_cnt = 2'd0;
      if (push_0 && push_1) begin
         push_cnt = 2'd2;
         if (in_lane1_first) begin
            slot_0 = lane_1;
            slot_1 = lane_0;
         end
      end else if (push_1) begin
         push_cnt = 2'd1;
         slot_0   = lane_1;
      end else if (push_0) begin
         push_cnt = 2'd1;
      end
   end

   assign out_valid = (fifo_count != '0);
   assign pop       = out_valid & out_ready;

   trace_fifo #(
      .DEPTH(DEPTH)
   ) u_fifo (
      .clk         (clk),
      .resetn      (resetn),
      .push_cnt    (push_cnt),
      .push_entry_0(slot_0),
      .push_entry_1(slot_1),
      .pop         (pop),
      .head        (head),
      .count       (fifo_count)
   );

   always_comb begin
      out_pc    = '0;
      out_wen   = '0;
      out_wnum  = '0;
      out_wdata = '0;
      if (out_valid) begin
         out_pc    = head.pc;
         out_wen   = head.wen;
         out_wnum  = head.wnum;
         out_wdata = head.wdata;
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         retired_cnt_q <= '0;
      end else if (pop) begin
         retired_cnt_q <= retired_cnt_q + 32'd1;
      end
   end

   assign retired_cnt = retired_cnt_q;

endmodule

// File: tb/tb_wb_trace_arbiter.sv
// Directed self-checking bench for wb_trace_arbiter with DEPTH=4.
module tb_wb_trace_arbiter;

   logic        clk = 1'b0;
   logic        resetn;
   logic [1:0]  in_valid;
   logic        in_lane1_first;
   logic [31:0] in_pc_0, in_pc_1;
   logic [3:0]  in_wen_0, in_wen_1;
   logic [4:0]  in_wnum_0, in_wnum_1;
   logic [31:0] in_wdata_0, in_wdata_1;
   logic        stall_req, out_valid, out_ready;
   logic [31:0] out_pc;
   logic [3:0]  out_wen;
   logic [4:0]  out_wnum;
   logic [31:0] out_wdata;
   logic [31:0] retired_cnt;

   int checks = 0;
   int failures = 0;
   logic [31:0] exp_retired = 32'd0;

   always #5 clk = ~clk;

   wb_trace_arbiter #(
      .DEPTH(4)
   ) dut (
      .clk           (clk),
      .resetn        (resetn),
      .in_valid      (in_valid),
      .in_lane1_first(in_lane1_first),
      .in_pc_0       (in_pc_0),
      .in_pc_1       (in_pc_1),
      .in_wen_0      (in_wen_0),
      .in_wen_1      (in_wen_1),
      .in_wnum_0     (in_wnum_0),
      .in_wnum_1     (in_wnum_1),
      .in_wdata_0    (in_wdata_0),
      .in_wdata_1    (in_wdata_1),
      .stall_req     (stall_req),
      .out_valid     (out_valid),
      .out_ready     (out_ready),
      .out_pc        (out_pc),
      .out_wen       (out_wen),
      .out_wnum      (out_wnum),
      .out_wdata     (out_wdata),
      .retired_cnt   (retired_cnt)
   );

   // Inputs change and outputs are sampled 1 time unit after the rising edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_lane0(input logic [31:0] pc, input logic [3:0] wen, input logic [4:0] wnum,
                            input logic [31:0] wdata);
      in_pc_0 = pc; in_wen_0 = wen; in_wnum_0 = wnum; in_wdata_0 = wdata;
   endtask

   task automatic set_lane1(input logic [31:0] pc, input logic [3:0] wen, input logic [4:0] wnum,
                            input logic [31:0] wdata);
      in_pc_1 = pc; in_wen_1 = wen; in_wnum_1 = wnum; in_wdata_1 = wdata;
   endtask

   task automatic clear_lanes();
      in_valid = 2'b00;
      in_lane1_first = 1'b0;
      set_lane0(32'd0, 4'd0, 5'd0, 32'd0);
      set_lane1(32'd0, 4'd0, 5'd0, 32'd0);
   endtask

   task automatic test_reset();
      resetn = 1'b0;
      out_ready = 1'b0;
      clear_lanes();
      step();
      step();
      resetn = 1'b1;
      step();
      // Fill to count=3: dual push then single push.
      in_valid = 2'b11;
      set_lane0(32'hA000_0000, 4'hF, 5'd1, 32'h11);
      set_lane1(32'hA000_0004, 4'hF, 5'd2, 32'h22);
      step();
      in_valid = 2'b01;
      set_lane0(32'hA000_0008, 4'hF, 5'd3, 32'h33);
      step();
      clear_lanes();
      checks++;
      if (stall_req !== 1'b1 || out_valid !== 1'b1) begin
         failures++;
         $display("FAIL reset_prefill: stall=%b valid=%b, required stall=1 valid=1", stall_req,
                  out_valid);
      end
      #2 resetn = 1'b0;
      #1;
      checks++;
      if (out_valid !== 1'b0 || stall_req !== 1'b0 || out_pc !== 32'd0 || out_wen !== 4'd0 ||
          out_wnum !== 5'd0 || out_wdata !== 32'd0 || retired_cnt !== 32'd0) begin
         failures++;
         $display("FAIL reset_async: valid=%b stall=%b pc=%h wen=%h wnum=%0d wdata=%h ret=%0d, required all 0",
                  out_valid, stall_req, out_pc, out_wen, out_wnum, out_wdata, retired_cnt);
      end
      #2 resetn = 1'b1;
      step();
      in_valid = 2'b01;
      set_lane0(32'h0000_0100, 4'hF, 5'd1, 32'h55);
      step();
      clear_lanes();
      checks++;
      if (out_valid !== 1'b1 || out_pc !== 32'h100 || out_wen !== 4'hF || out_wnum !== 5'd1 ||
          out_wdata !== 32'h55) begin
         failures++;
         $display("FAIL reset_push_after: valid=%b pc=%h wen=%h wnum=%0d wdata=%h, required 1 100 f 1 55",
                  out_valid, out_pc, out_wen, out_wnum, out_wdata);
      end
      out_ready = 1'b1;
      step();
      exp_retired = 32'd1;
      checks++;
      if (out_valid !== 1'b0 || retired_cnt !== exp_retired) begin
         failures++;
         $display("FAIL reset_pop_after: valid=%b ret=%0d, required valid=0 ret=%0d", out_valid,
                  retired_cnt, exp_retired);
      end
   endtask

   task automatic test_dual(input logic lane1_first, input logic [31:0] first_pc,
                            input logic [31:0] second_pc);
      out_ready = 1'b1;
      in_valid = 2'b11;
      in_lane1_first = lane1_first;
      set_lane0(32'hBFC0_0000, 4'hF, 5'd2, 32'h1);
      set_lane1(32'hBFC0_0004, 4'hF, 5'd3, 32'h2);
      step();
      clear_lanes();
      checks++;
      if (out_valid !== 1'b1 || out_pc !== first_pc) begin
         failures++;
         $display("FAIL dual_first l1f=%b: valid=%b pc=%h, required 1 %h", lane1_first, out_valid,
                  out_pc, first_pc);
      end
      step();
      checks++;
      if (out_valid !== 1'b1 || out_pc !== second_pc) begin
         failures++;
         $display("FAIL dual_second l1f=%b: valid=%b pc=%h, required 1 %h", lane1_first, out_valid,
                  out_pc, second_pc);
      end
      step();
      exp_retired += 32'd2;
      checks++;
      if (out_valid !== 1'b0 || retired_cnt !== exp_retired) begin
         failures++;
         $display("FAIL dual_done l1f=%b: valid=%b ret=%0d, required 0 %0d", lane1_first,
                  out_valid, retired_cnt, exp_retired);
      end
   endtask

   task automatic test_dropped_lane();
      out_ready = 1'b1;
      in_valid = 2'b11;
      set_lane0(32'hBFC0_0008, 4'h0, 5'd4, 32'h9999);
      set_lane1(32'hBFC0_0010, 4'h3, 5'd5, 32'hABCD);
      step();
      clear_lanes();
      checks++;
      if (out_valid !== 1'b1 || out_pc !== 32'hBFC0_0010 || out_wen !== 4'h3 ||
          out_wnum !== 5'd5 || out_wdata !== 32'hABCD) begin
         failures++;
         $display("FAIL dropped_head: valid=%b pc=%h wen=%h wnum=%0d wdata=%h, required 1 bfc00010 3 5 abcd",
                  out_valid, out_pc, out_wen, out_wnum, out_wdata);
      end
      step();
      exp_retired += 32'd1;
      checks++;
      if (out_valid !== 1'b0 || retired_cnt !== exp_retired) begin
         failures++;
         $display("FAIL dropped_done: valid=%b ret=%0d, required 0 %0d", out_valid, retired_cnt,
                  exp_retired);
      end
   endtask

   task automatic test_backpressure();
      logic [31:0] exp_pc [4];
      exp_pc[0] = 32'h1000; exp_pc[1] = 32'h1004; exp_pc[2] = 32'h1008; exp_pc[3] = 32'h100C;
      out_ready = 1'b0;
      in_valid = 2'b11;
      set_lane0(32'h1000, 4'hF, 5'd6, 32'h60);
      set_lane1(32'h1004, 4'hF, 5'd7, 32'h70);
      step();
      checks++;
      if (stall_req !== 1'b0 || out_pc !== 32'h1000) begin
         failures++;
         $display("FAIL bp_count2: stall=%b pc=%h, required 0 1000", stall_req, out_pc);
      end
      set_lane0(32'h1008, 4'hF, 5'd8, 32'h80);
      set_lane1(32'h100C, 4'hF, 5'd9, 32'h90);
      step();
      checks++;
      if (stall_req !== 1'b1) begin
         failures++;
         $display("FAIL bp_count4: stall=%b, required 1", stall_req);
      end
      set_lane0(32'h1010, 4'hF, 5'd10, 32'hA0);
      set_lane1(32'h1014, 4'hF, 5'd11, 32'hB0);
      step();
      checks++;
      if (stall_req !== 1'b1 || out_pc !== 32'h1000) begin
         failures++;
         $display("FAIL bp_ignored: stall=%b pc=%h, required 1 1000", stall_req, out_pc);
      end
      in_valid = 2'b00;
      out_ready = 1'b1;
      #1;
      for (int i = 0; i < 4; i++) begin
         checks++;
         if (out_valid !== 1'b1 || out_pc !== exp_pc[i] || stall_req !== ((4 - i) > 2)) begin
            failures++;
            $display("FAIL bp_drain[%0d]: valid=%b pc=%h stall=%b, required 1 %h %b", i, out_valid,
                     out_pc, stall_req, exp_pc[i], ((4 - i) > 2));
         end
         step();
      end
      exp_retired += 32'd4;
      checks++;
      if (out_valid !== 1'b0 || stall_req !== 1'b0 || retired_cnt !== exp_retired) begin
         failures++;
         $display("FAIL bp_empty: valid=%b stall=%b ret=%0d, required 0 0 %0d", out_valid,
                  stall_req, retired_cnt, exp_retired);
      end
      in_valid = 2'b11;
      step();
      clear_lanes();
      checks++;
      if (out_pc !== 32'h1010 || out_wnum !== 5'd10) begin
         failures++;
         $display("FAIL bp_represent_a: pc=%h wnum=%0d, required 1010 10", out_pc, out_wnum);
      end
      step();
      checks++;
      if (out_pc !== 32'h1014 || out_wdata !== 32'hB0) begin
         failures++;
         $display("FAIL bp_represent_b: pc=%h wdata=%h, required 1014 b0", out_pc, out_wdata);
      end
      step();
      exp_retired += 32'd2;
      checks++;
      if (out_valid !== 1'b0 || retired_cnt !== exp_retired) begin
         failures++;
         $display("FAIL bp_final: valid=%b ret=%0d, required 0 %0d", out_valid, retired_cnt,
                  exp_retired);
      end
   endtask

   task automatic test_back_to_back();
      out_ready = 1'b0;
      in_valid = 2'b01;
      set_lane0(32'h2000, 4'h1, 5'd0, 32'hC0);
      step();
      out_ready = 1'b1;
      in_valid = 2'b10;
      for (int k = 0; k < 6; k++) begin
         set_lane1(32'h2004 + 32'(4 * k), 4'h1, 5'd0, 32'hD0 + 32'(k));
         step();
         exp_retired += 32'd1;
         checks++;
         if (out_valid !== 1'b1 || stall_req !== 1'b0 || out_pc !== 32'h2004 + 32'(4 * k) ||
             out_wnum !== 5'd0 || out_wen !== 4'h1 || retired_cnt !== exp_retired) begin
            failures++;
            $display("FAIL b2b[%0d]: valid=%b stall=%b pc=%h wnum=%0d wen=%h ret=%0d, required 1 0 %h 0 1 %0d",
                     k, out_valid, stall_req, out_pc, out_wnum, out_wen, retired_cnt,
                     32'h2004 + 32'(4 * k), exp_retired);
         end
      end
      clear_lanes();
      step();
      exp_retired += 32'd1;
      checks++;
      if (out_valid !== 1'b0 || retired_cnt !== exp_retired) begin
         failures++;
         $display("FAIL b2b_done: valid=%b ret=%0d, required 0 %0d", out_valid, retired_cnt,
                  exp_retired);
      end
   endtask

   initial begin
      test_reset();
      test_dual(1'b0, 32'hBFC0_0000, 32'hBFC0_0004);
      test_dual(1'b1, 32'hBFC0_0004, 32'hBFC0_0000);
      test_dropped_lane();
      test_backpressure();
      test_back_to_back();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/wb_trace_arbiter.md
# wb_trace_arbiter

Serializes the two write-back lanes of the dual-issue pipeline onto a single-lane debug trace port. Each cycle it accepts up to two retired register writes from the WB stage, in program order, and buffers them in a small FIFO. It drains them one per cycle toward the trace comparator. When buffer space runs short it raises a stall request to the hazard unit, which holds the WB stage (`ws_stall`).

## Interface
Parameters:
- `DEPTH`, 4: FIFO entries; power of two, ≥ 4.

Ports:
- `clk` in 1: clock.
- `resetn` in 1: reset; asynchronous, active-low.
- `in_valid` in 2: per-lane retire valid; bit0 = lane 0, bit1 = lane 1.
- `in_lane1_first` in 1: 1 = lane 1 is older when both lanes are valid.
- `in_pc_0` / `in_pc_1` in 32: lane PC.
- `in_wen_0` / `in_wen_1` in 4: lane byte write enables.
- `in_wnum_0` / `in_wnum_1` in 5: destination register.
- `in_wdata_0` / `in_wdata_1` in 32: write data.
- `stall_req` out 1: to hazard unit; WB must hold its lanes while high.
- `out_valid` out 1: trace entry present.
- `out_ready` in 1: trace consumer accepts the entry.
- `out_pc` out 32: head entry PC.
- `out_wen` out 4: head entry byte enables.
- `out_wnum` out 5: head entry register number.
- `out_wdata` out 32: head entry write data.
- `retired_cnt` out 32: count of entries popped.

## Operation
- Lane qualification: a lane is pushable when `in_valid[i]=1`, `in_wen_i≠0`, and `stall_req=0`.
  - Lanes with `wen=0` are dropped silently.
  - `wnum=0` with `wen≠0` is pushed unchanged.
- Lanes presented while `stall_req=1` are ignored. WB holds them and re-presents them later.
- Ordering with two pushable lanes: the older lane goes to the lower slot. The older lane is lane 1 if `in_lane1_first=1`, otherwise lane 0.
- A single pushable lane occupies one slot. Push count per cycle is 0, 1 or 2.
- Pop: occurs when `out_valid & out_ready`. The read pointer advances by 1 and `retired_cnt` increments (32-bit, wraps to 0).
- `count_next = count + pushes − pop`. Pointers are log2(DEPTH) bits and wrap modulo DEPTH.
- `stall_req = (DEPTH − count) < 2`, combinational from registered `count` only, so there is no loop through `in_valid`.
  - Overflow is therefore impossible.
  - A push attempted while `stall_req=1` changes no state.
- Output gating:
  - `out_valid = (count≠0)`.
  - `out_pc`, `out_wen`, `out_wnum` and `out_wdata` show the head entry when valid and all-zero otherwise.

## Timing
- Reset values, asynchronous on `resetn` low:
  - count, pointers and `retired_cnt` = 0.
  - `out_valid=0`, `stall_req=0`, all `out_*` = 0.
- Reset mid-operation discards all buffered entries immediately; the FIFO storage needs no clearing.
- Latency: an entry pushed at edge N is visible on `out_*` after edge N when the FIFO was empty. There is no same-cycle bypass.
- Push and pop in the same cycle are legal at any occupancy, including empty+push (the pop only sees prior contents) and full (no push is possible).
- Throughput: sustained one entry per cycle out. Dual retire every cycle fills the FIFO and throttles WB through `stall_req`.
- `stall_req` deasserts in the cycle after a pop brings count ≤ DEPTH−2.

## Structure
- `mycpu.h` gains the following; the entry layout is {pc, wen, wnum, wdata}.
  - `` `TRACE_ENTRY_WD `` = 73.
  - Field offset macros for the entry.
- Sub-module `trace_fifo`: a 2-write/1-read circular buffer with parameter `DEPTH`.
  - Inputs: push count and two entries in order.
  - Outputs: head entry and count.
- `wb_trace_arbiter` holds lane qualification, ordering, stall logic, output gating and `retired_cnt`.

## Test plan
1. Reset: pull `resetn` low while count=3 and `out_ready=0`.
   - Immediately: `out_valid=0`, `stall_req=0`, all `out_*=0`, `retired_cnt=0`.
   - After release, a single push appears normally.
2. Dual retire, lane 0 older, `out_ready=1`: lane 0 = {0xBFC00000, 0xF, 2, 0x1}, lane 1 = {0xBFC00004, 0xF, 3, 0x2}, `in_lane1_first=0`.
   - Edge+1: `out_pc=0xBFC00000`.
   - Edge+2: `out_pc=0xBFC00004`.
   - `retired_cnt` = 2.
3. Same stimulus with `in_lane1_first=1`: the output order is 0xBFC00004, then 0xBFC00000.
4. Dropped lane: lane 0 has `wen=0`; lane 1 = {0xBFC00010, 0x3, 5, 0xABCD}.
   - Only 0xBFC00010 is output, with `out_wen=0x3`.
   - `retired_cnt` +1.
5. Backpressure, `DEPTH=4`, `out_ready=0`:
   - Dual push: count=2, `stall_req=0`.
   - Second dual push: count=4, `stall_req=1`.
   - Third presentation: ignored, count stays 4.
   - Raise `out_ready`: four entries drain in order, and `stall_req` drops the cycle after count reaches 2.
   - Re-present the third pair: it is accepted.
6. Push/pop concurrency: hold count=1 with `out_ready=1` and present single-lane retires every cycle.
   - count stays 1.
   - `out_valid` stays 1 continuously.
   - `retired_cnt` increments each cycle.
